// File: rtl/fu_alu_sched.sv
// Round-robin scheduler sharing one integer ALU functional unit among NREQ issue requesters.
// It drives the FU EN/finish protocol and holds each tagged result until the CDB side accepts it.
module fu_alu_sched #(
  parameter int NREQ    = 2,
  parameter int TAGW    = 4,
  parameter int TIMEOUT = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [4*NREQ-1:0]    req_ctrl,
  input  logic [32*NREQ-1:0]   req_a,
  input  logic [32*NREQ-1:0]   req_b,
  input  logic [TAGW*NREQ-1:0] req_tag,
  output logic                 fu_en,
  output logic [3:0]           fu_ctrl,
  output logic [31:0]          fu_a,
  output logic [31:0]          fu_b,
  input  logic [31:0]          fu_res,
  input  logic                 fu_zero,
  input  logic                 fu_overflow,
  input  logic                 fu_finish,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [31:0]          res_data,
  output logic [TAGW-1:0]      res_tag,
  output logic                 res_zero,
  output logic                 res_overflow,
  output logic                 busy,
  output logic                 err
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  // Handshakes: a requester transfer happens on a rising edge where req_valid[i] and
  // req_ready[i] are both high; a result leaves on an edge where res_valid and res_ready are high.

  logic [1:0]      state;
  logic [PW-1:0]   ptr;
  logic [CW-1:0]   cnt;
  logic [3:0]      iss_ctrl;
  logic [31:0]     iss_a;
  logic [31:0]     iss_b;
  logic [TAGW-1:0] iss_tag;

  logic            grant_ok;
  logic            grant;
  logic            win_found;
  logic [PW-1:0]   win_idx;

  // Scan from the slot after the last winner so every requester gets a turn.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!win_found && req_valid[(int'(ptr) + k) % NREQ]) begin
        win_found = 1'b1;
        win_idx   = PW'((int'(ptr) + k) % NREQ);
      end
    end
  end

  assign grant_ok = (state == S_IDLE) || ((state == S_DONE) && res_ready);
  assign grant    = grant_ok && win_found;

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = grant && (win_idx == PW'(i));
    end
  end

  assign fu_en     = (state == S_ISSUE);
  assign fu_ctrl   = iss_ctrl;
  assign fu_a      = iss_a;
  assign fu_b      = iss_b;
  assign res_valid = (state == S_DONE);
  assign busy      = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      ptr          <= PW'(NREQ - 1);
      cnt          <= '0;
      err          <= 1'b0;
      iss_ctrl     <= '0;
      iss_a        <= '0;
      iss_b        <= '0;
      iss_tag      <= '0;
      res_data     <= '0;
      res_tag      <= '0;
      res_zero     <= 1'b0;
      res_overflow <= 1'b0;
    end else begin
      if (grant) begin
        iss_ctrl <= req_ctrl[4*int'(win_idx) +: 4];
        iss_a    <= req_a[32*int'(win_idx) +: 32];
        iss_b    <= req_b[32*int'(win_idx) +: 32];
        iss_tag  <= req_tag[TAGW*int'(win_idx) +: TAGW];
        ptr      <= win_idx;
      end
      case (state)
        S_IDLE: begin
          if (grant) state <= S_ISSUE;
        end
        S_ISSUE: begin
          state <= S_WAIT;
          cnt   <= '0;
        end
        S_WAIT: begin
          if (fu_finish) begin
            res_data     <= fu_res;
            res_tag      <= iss_tag;
            res_zero     <= fu_zero;
            res_overflow <= fu_overflow;
            state        <= S_DONE;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            // The FU never answered: drop the op without producing a result.
            err   <= 1'b1;
            state <= S_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DONE: begin
          if (res_ready) state <= grant ? S_ISSUE : S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fu_alu_sched.sv
// Directed bench for fu_alu_sched: vector table of single ops plus round-robin,
// backpressure, timeout and mid-operation reset sequences against a small ALU FU model.
module tb_fu_alu_sched;

  localparam int NREQ    = 2;
  localparam int TAGW    = 4;
  localparam int TIMEOUT = 8;

  localparam logic [3:0] OP_AND  = 4'd0;
  localparam logic [3:0] OP_OR   = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_SUB  = 4'd6;
  localparam logic [3:0] OP_SLT  = 4'd7;
  localparam logic [3:0] OP_SLTU = 4'd8;

  logic                 clk;
  logic                 rst;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [4*NREQ-1:0]    req_ctrl;
  logic [32*NREQ-1:0]   req_a;
  logic [32*NREQ-1:0]   req_b;
  logic [TAGW*NREQ-1:0] req_tag;
  logic                 fu_en;
  logic [3:0]           fu_ctrl;
  logic [31:0]          fu_a;
  logic [31:0]          fu_b;
  logic [31:0]          fu_res;
  logic                 fu_zero;
  logic                 fu_overflow;
  logic                 fu_finish;
  logic                 res_valid;
  logic                 res_ready;
  logic [31:0]          res_data;
  logic [TAGW-1:0]      res_tag;
  logic                 res_zero;
  logic                 res_overflow;
  logic                 busy;
  logic                 err;
  logic                 fu_block;

  int n_checks = 0;
  int n_fail   = 0;

  logic [36:0] exp_q[$];

  typedef struct {
    int          idx;
    logic [3:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  tag;
    logic [31:0] exp_data;
    logic        exp_zero;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs[8];

  fu_alu_sched #(.NREQ(NREQ), .TAGW(TAGW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_ctrl(req_ctrl),
    .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
    .fu_en(fu_en), .fu_ctrl(fu_ctrl), .fu_a(fu_a), .fu_b(fu_b),
    .fu_res(fu_res), .fu_zero(fu_zero), .fu_overflow(fu_overflow), .fu_finish(fu_finish),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_tag(res_tag),
    .res_zero(res_zero), .res_overflow(res_overflow), .busy(busy), .err(err)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ALU functional-unit model: answers one cycle after EN unless blocked.
  function automatic logic [33:0] alu(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic        v;
    r = 32'd0;
    v = 1'b0;
    case (c)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_ADD:  begin r = a + b; v = (a[31] == b[31]) && (r[31] != a[31]); end
      OP_SUB:  begin r = a - b; v = (a[31] != b[31]) && (r[31] != a[31]); end
      OP_SLT:  r = {31'd0, $signed(a) < $signed(b)};
      OP_SLTU: r = {31'd0, a < b};
      default: r = 32'd0;
    endcase
    return {(r == 32'd0), v, r};
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      fu_finish   <= 1'b0;
      fu_res      <= 32'd0;
      fu_zero     <= 1'b0;
      fu_overflow <= 1'b0;
    end else begin
      fu_finish <= fu_en && !fu_block;
      if (fu_en) {fu_zero, fu_overflow, fu_res} <= alu(fu_ctrl, fu_a, fu_b);
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic load_req(input int idx, input logic [3:0] c, input logic [31:0] a,
                          input logic [31:0] b, input logic [3:0] t);
    req_ctrl[4*idx +: 4]       = c;
    req_a[32*idx +: 32]        = a;
    req_b[32*idx +: 32]        = b;
    req_tag[TAGW*idx +: TAGW]  = t;
  endtask

  task automatic run_single(input vec_t v);
    int cyc;
    req_valid = '0;
    load_req(v.idx, v.ctrl, v.a, v.b, v.tag);
    req_valid[v.idx] = 1'b1;
    #1;
    cyc = 0;
    while (req_ready[v.idx] !== 1'b1 && cyc < 8) begin
      tick();
      cyc++;
    end
    check("single_grant", 64'(req_ready), 64'(1 << v.idx));
    tick();
    req_valid = '0;
    #1;
    check("single_fu_en", 64'(fu_en), 64'd1);
    check("single_fu_ctrl", 64'(fu_ctrl), 64'(v.ctrl));
    check("single_fu_a", 64'(fu_a), 64'(v.a));
    check("single_fu_b", 64'(fu_b), 64'(v.b));
    tick();
    check("single_wait_en", 64'(fu_en), 64'd0);
    check("single_wait_valid", 64'(res_valid), 64'd0);
    tick();
    check("single_res_valid", 64'(res_valid), 64'd1);
    check("single_res_data", 64'(res_data), 64'(v.exp_data));
    check("single_res_tag", 64'(res_tag), 64'(v.tag));
    check("single_res_zero", 64'(res_zero), 64'(v.exp_zero));
    check("single_res_ovf", 64'(res_overflow), 64'(v.exp_ovf));
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    #1;
    check("single_drain_valid", 64'(res_valid), 64'd0);
    check("single_drain_busy", 64'(busy), 64'd0);
  endtask

  // Scoreboard-driven round-robin run: both requesters stay valid for four grants.
  task automatic run_round_robin();
    int n_grant;
    int n_res;
    int last;
    logic [36:0] e;
    n_grant = 0;
    n_res   = 0;
    last    = -1;
    load_req(0, OP_SUB, 32'd5, 32'd5, 4'd1);
    load_req(1, OP_OR, 32'h0000_00F0, 32'h0000_000F, 4'd2);
    req_valid = 2'b11;
    res_ready = 1'b1;
    #1;
    for (int cyc = 0; cyc < 40 && n_res < 4; cyc++) begin
      if (req_ready != '0) begin
        check("rr_grant", 64'(req_ready), 64'(1 << (n_grant % 2)));
        if (n_grant % 2 == 0) exp_q.push_back({1'b1, 4'd1, 32'h0000_0000});
        else                  exp_q.push_back({1'b0, 4'd2, 32'h0000_00FF});
        n_grant++;
      end
      if (res_valid) begin
        if (exp_q.size() == 0) begin
          check("rr_unexpected_result", 64'(res_data), 64'hDEAD);
        end else begin
          e = exp_q.pop_front();
          check("rr_result", 64'({res_zero, res_tag, res_data}), 64'(e));
        end
        if (last >= 0) check("rr_spacing", 64'(cyc - last), 64'd3);
        last = cyc;
        n_res++;
      end
      tick();
      if (n_grant >= 4) req_valid = '0;
      #1;
    end
    check("rr_result_count", 64'(n_res), 64'd4);
    check("rr_grant_count", 64'(n_grant), 64'd4);
    res_ready = 1'b0;
    req_valid = '0;
    tick();
    check("rr_idle", 64'(busy), 64'd0);
  endtask

  task automatic run_backpressure();
    int cyc;
    load_req(0, OP_ADD, 32'd2, 32'd3, 4'd5);
    req_valid = 2'b01;
    #1;
    check("bp_grant0", 64'(req_ready), 64'b01);
    tick();
    req_valid = '0;
    cyc = 0;
    while (res_valid !== 1'b1 && cyc < 10) begin
      tick();
      cyc++;
    end
    check("bp_res_valid", 64'(res_valid), 64'd1);
    load_req(1, OP_OR, 32'h1, 32'h2, 4'd6);
    req_valid = 2'b10;
    #1;
    for (int k = 0; k < 5; k++) begin
      check("bp_hold_valid", 64'(res_valid), 64'd1);
      check("bp_hold_data", 64'({res_tag, res_data}), 64'({4'd5, 32'd5}));
      check("bp_no_ready", 64'(req_ready), 64'd0);
      check("bp_no_en", 64'(fu_en), 64'd0);
      tick();
    end
    res_ready = 1'b1;
    #1;
    check("bp_grant1_same_cycle", 64'(req_ready), 64'b10);
    tick();
    res_ready = 1'b0;
    req_valid = '0;
    #1;
    check("bp_issue_en", 64'(fu_en), 64'd1);
    check("bp_issue_b", 64'(fu_b), 64'h2);
    check("bp_issue_valid_low", 64'(res_valid), 64'd0);
    tick();
    tick();
    check("bp_second_res", 64'({res_valid, res_tag, res_data}), 64'({1'b1, 4'd6, 32'd3}));
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("bp_idle", 64'(busy), 64'd0);
  endtask

  task automatic run_timeout();
    fu_block = 1'b1;
    load_req(0, OP_ADD, 32'd1, 32'd1, 4'd7);
    req_valid = 2'b01;
    #1;
    check("to_grant", 64'(req_ready), 64'b01);
    tick();
    req_valid = '0;
    tick();
    for (int k = 0; k < TIMEOUT; k++) begin
      check("to_wait_busy", 64'(busy), 64'd1);
      check("to_wait_no_res", 64'(res_valid), 64'd0);
      check("to_wait_no_err", 64'(err), 64'd0);
      tick();
    end
    check("to_err_set", 64'(err), 64'd1);
    check("to_back_idle", 64'(busy), 64'd0);
    check("to_no_res", 64'(res_valid), 64'd0);
    fu_block = 1'b0;
  endtask

  task automatic run_reset_mid_op();
    load_req(1, OP_ADD, 32'd9, 32'd9, 4'd4);
    req_valid = 2'b10;
    #1;
    tick();
    req_valid = '0;
    tick();
    check("rst_in_wait", 64'({busy, fu_en, res_valid}), 64'b100);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_res_valid", 64'(res_valid), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_fu_en", 64'(fu_en), 64'd0);
    tick();
    check("rst_stays_idle", 64'({busy, res_valid}), 64'd0);
  endtask

  initial begin
    vecs[0] = '{0, OP_ADD,  32'h7FFF_FFFF, 32'h0000_0001, 4'd3, 32'h8000_0000, 1'b0, 1'b1};
    vecs[1] = '{1, OP_SUB,  32'h0000_0005, 32'h0000_0005, 4'd1, 32'h0000_0000, 1'b1, 1'b0};
    vecs[2] = '{0, OP_OR,   32'h0000_00F0, 32'h0000_000F, 4'd2, 32'h0000_00FF, 1'b0, 1'b0};
    vecs[3] = '{1, OP_AND,  32'hFF00_FF00, 32'h0FF0_0FF0, 4'd9, 32'h0F00_0F00, 1'b0, 1'b0};
    vecs[4] = '{0, OP_SLT,  32'hFFFF_FFFF, 32'h0000_0001, 4'd10, 32'h0000_0001, 1'b0, 1'b0};
    vecs[5] = '{1, OP_SLTU, 32'h0000_0001, 32'hFFFF_FFFF, 4'd15, 32'h0000_0001, 1'b0, 1'b0};
    vecs[6] = '{0, OP_SUB,  32'h8000_0000, 32'h0000_0001, 4'd12, 32'h7FFF_FFFF, 1'b0, 1'b1};
    vecs[7] = '{1, OP_ADD,  32'hFFFF_FFFF, 32'h0000_0001, 4'd0, 32'h0000_0000, 1'b1, 1'b0};

    rst       = 1'b1;
    fu_block  = 1'b0;
    req_valid = '0;
    req_ctrl  = '0;
    req_a     = '0;
    req_b     = '0;
    req_tag   = '0;
    res_ready = 1'b0;
    repeat (3) tick();
    check("reset_outputs", 64'({req_ready, fu_en, fu_ctrl, res_valid, res_zero, res_overflow, busy, err}), 64'd0);
    check("reset_fu_data", 64'({fu_a, fu_b}), 64'd0);
    check("reset_res_data", 64'({res_tag, res_data}), 64'd0);
    rst = 1'b0;
    tick();

    // Pointer resets to NREQ-1, so requester 0 must win the first contested grant.
    run_round_robin();

    for (int i = 0; i < 8; i++) run_single(vecs[i]);

    run_backpressure();
    run_timeout();
    run_single(vecs[2]);
    check("to_err_sticky", 64'(err), 64'd1);

    run_reset_mid_op();
    run_single('{0, OP_SLTU, 32'h0000_0001, 32'hFFFF_FFFF, 4'd8, 32'h0000_0001, 1'b0, 1'b0});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
